// File: rtl/video_timing_controller.sv
// Video raster timing generator: frame/line counters, registered pixel-fetch requests and
// {de, vsync, hsync} aligned to the pixel source latency, plus a sticky underflow flag.
module video_timing_controller #(
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33,
    parameter bit          H_POL     = 1'b0,
    parameter bit          V_POL     = 1'b0,
    parameter int unsigned FETCH_LAT = 2
) (
    input  logic        i_hdmi_clk,
    input  logic        i_reset_n,
    input  logic        i_enable,
    input  logic        i_rgb_valid,
    input  logic        i_clr_underflow,
    output logic        o_req,
    output logic [11:0] o_x,
    output logic [11:0] o_y,
    output logic        o_frame_start,
    output logic [2:0]  o_hve,
    output logic        o_busy,
    output logic        o_underflow
);

    localparam logic [11:0] HTotal     = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam logic [11:0] VTotal     = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP);
    localparam logic [11:0] HActive    = 12'(H_ACTIVE);
    localparam logic [11:0] VActive    = 12'(V_ACTIVE);
    localparam logic [11:0] HSyncStart = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HSyncEnd   = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] VSyncStart = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VSyncEnd   = 12'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [2:0]  HveIdle    = {1'b0, ~V_POL, ~H_POL};

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e      state_q;
    logic [11:0] h_q, v_q;
    logic        line_end, frame_end;

    assign line_end  = (h_q == HTotal - 12'd1);
    assign frame_end = line_end && (v_q == VTotal - 12'd1);

    always_ff @(posedge i_hdmi_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= StIdle;
            h_q     <= '0;
            v_q     <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    h_q <= '0;
                    v_q <= '0;
                    if (i_enable) state_q <= StRun;
                end
                StRun: begin
                    // Enable is only honoured at the frame boundary so frames always complete.
                    if (frame_end) begin
                        h_q <= '0;
                        v_q <= '0;
                        if (!i_enable) state_q <= StIdle;
                    end else if (line_end) begin
                        h_q <= '0;
                        v_q <= v_q + 12'd1;
                    end else begin
                        h_q <= h_q + 12'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    logic running, pix_d, hs_d, vs_d;

    always_comb begin
        running = (state_q == StRun);
        pix_d   = running && (h_q < HActive) && (v_q < VActive);
        hs_d    = (running && (h_q >= HSyncStart) && (h_q < HSyncEnd)) ? H_POL : ~H_POL;
        vs_d    = (running && (v_q >= VSyncStart) && (v_q < VSyncEnd)) ? V_POL : ~V_POL;
    end

    logic        req_q, fs_q, uf_q;
    logic [11:0] x_q, y_q;
    // Stage 0 is the raw hve aligned with o_req; stage FETCH_LAT drives o_hve.
    logic [2:0]  hve_q [FETCH_LAT+1];

    always_ff @(posedge i_hdmi_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            req_q <= 1'b0;
            fs_q  <= 1'b0;
            x_q   <= '0;
            y_q   <= '0;
            uf_q  <= 1'b0;
            for (int unsigned i = 0; i <= FETCH_LAT; i++) hve_q[i] <= HveIdle;
        end else begin
            req_q    <= pix_d;
            fs_q     <= running && (h_q == 12'd0) && (v_q == 12'd0);
            x_q      <= pix_d ? h_q : 12'd0;
            y_q      <= pix_d ? v_q : 12'd0;
            hve_q[0] <= {pix_d, vs_d, hs_d};
            for (int unsigned i = 1; i <= FETCH_LAT; i++) hve_q[i] <= hve_q[i-1];
            uf_q     <= (o_hve[2] && !i_rgb_valid) || (uf_q && !i_clr_underflow);
        end
    end

    assign o_req         = req_q;
    assign o_x           = x_q;
    assign o_y           = y_q;
    assign o_frame_start = fs_q;
    assign o_hve         = hve_q[FETCH_LAT];
    assign o_busy        = (state_q == StRun);
    assign o_underflow   = uf_q;

endmodule

// File: doc/video_timing_controller.md
VIDEO_TIMING_CONTROLLER -- requirements
Module: video_timing_controller

Interface
REQ-001 Parameters (name, default, meaning): H_ACTIVE 640 visible pixels/line; H_FP 16 front porch; H_SYNC 96 hsync width; H_BP 48 back porch; V_ACTIVE 480 visible lines; V_FP 10; V_SYNC 2; V_BP 33; H_POL 0 hsync level during pulse; V_POL 0 vsync level during pulse; FETCH_LAT 2 pixel-source latency in cycles, 0..15.
REQ-002 Ports (name direction width meaning): i_hdmi_clk in 1 pixel clock; i_reset_n in 1 asynchronous active-low reset; i_enable in 1 run request; i_rgb_valid in 1 pixel source has data for current o_hve cycle; i_clr_underflow in 1 clear sticky flag; o_req out 1 fetch pixel at o_x/o_y; o_x out 12 column; o_y out 12 row; o_frame_start out 1 one-cycle frame pulse; o_hve out 3 {display_enable, vsync, hsync} to hdmi block; o_busy out 1 state==RUN; o_underflow out 1 sticky underflow.
REQ-003 The block SHALL use a single clock, i_hdmi_clk; reset i_reset_n SHALL be asynchronous and active-low.

Function
REQ-004 H_TOTAL = sum of H params, V_TOTAL = sum of V params; counters h (0..H_TOTAL-1), v (0..V_TOTAL-1), 12 bits each.
REQ-005 States: IDLE, RUN; IDLE with i_enable=1 at an edge -> RUN with h=0, v=0 after that edge.
REQ-006 In RUN, h increments each cycle; at h=H_TOTAL-1, h->0 and v increments; at v=V_TOTAL-1 and h=H_TOTAL-1, v->0.
REQ-007 At the last frame cycle (h=H_TOTAL-1, v=V_TOTAL-1), i_enable=0 -> IDLE, counters to 0; i_enable=1 -> next frame starts seamlessly; i_enable deassertion elsewhere is ignored (frame always completes).
REQ-008 In IDLE, counters hold 0.
REQ-009 Request stage (registered, one cycle after the counter value): o_req = RUN & h<H_ACTIVE & v<V_ACTIVE; o_x=h, o_y=v when o_req, else 0; o_frame_start = RUN & h=0 & v=0.
REQ-010 Raw hve (same stage as o_req): de = o_req; hsync = H_POL when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC, else ~H_POL; vsync = V_POL when V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC (whole lines, h-independent), else ~V_POL; in IDLE de=0, syncs inactive.
REQ-011 o_hve SHALL equal raw hve delayed by exactly FETCH_LAT cycles (FETCH_LAT=0: same cycle as o_req); delay line registers reset to {0, ~V_POL, ~H_POL}.
REQ-012 Pixel for o_req in cycle t SHALL be presented on o_hve[2] in cycle t+FETCH_LAT.
REQ-013 Underflow: at an edge with o_hve[2]=1 and i_rgb_valid=0, o_underflow SHALL set; i_clr_underflow=1 clears it; simultaneous set and clear -> set wins.
REQ-014 i_rgb_valid is don't-care when o_hve[2]=0.
REQ-015 After RUN->IDLE, the delay line SHALL still drain the final FETCH_LAT cycles of raw hve.

Reset
REQ-016 i_reset_n=0 SHALL immediately (asynchronously) force: state IDLE, h=v=0, o_req=0, o_x=o_y=0, o_frame_start=0, o_busy=0, o_underflow=0, o_hve={0, ~V_POL, ~H_POL} including all delay stages.
REQ-017 Reset asserted mid-frame SHALL abort the frame; after release the block SHALL remain IDLE until i_enable=1 is sampled.

Verification (bench params H 4/1/1/2, V 2/1/1/1, H_TOTAL 8, V_TOTAL 5, FETCH_LAT 2, POL 0)
REQ-018 Reset release, i_enable=1 at edge E0 -> o_busy=1 after E0; o_frame_start=1 for exactly one cycle after E1; o_req high 4 cycles with o_x 0,1,2,3, o_y 0; o_hve[2] high 2 cycles later.
REQ-019 Free run 2 frames -> o_hve[0]=0 exactly at h=5 each line (1 cycle per 8), o_hve[1]=0 for all 8 cycles of v=3 only, 8 de cycles per frame, o_frame_start period 40 cycles.
REQ-020 i_enable dropped at h=2,v=1 -> frame completes through h=7,v=4, then IDLE, o_busy=0, o_hve settles to {0,1,1} after 2 more cycles; no further o_req.
REQ-021 i_rgb_valid=0 during one de cycle -> o_underflow=1 and stays 1; i_clr_underflow=1 at edge with another underflow -> stays 1; clear without underflow -> 0.
REQ-022 i_reset_n=0 asserted mid-line, between edges -> all outputs take reset values without a clock edge; after release with i_enable=1 the next frame starts at x=0, y=0.
